// File: rtl/ser2par_cdc_pkg.sv
// Shared constants for the serial-to-parallel CDC block.
`timescale 1ns/1ps
package ser2par_cdc_pkg;
  localparam int DW_DEF          = 8;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/ser2par_cdc_if.sv
// Serial input, parallel valid/ready output and status pulses of ser2par_cdc.
`timescale 1ns/1ps
interface ser2par_cdc_if
  import ser2par_cdc_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          wra_n;
  logic          da;
  logic [DW-1:0] db;
  logic          db_valid;
  logic          db_ready;
  logic          short_frame;
  logic          overflow;

  // Producer/consumer side (drives serial input, consumes parallel words)
  modport master (
    output wra_n, da, db_ready,
    input  db, db_valid, short_frame, overflow
  );

  // Converter side
  modport slave (
    input  wra_n, da, db_ready,
    output db, db_valid, short_frame, overflow
  );
endinterface

// File: rtl/ser2par_cdc_sync.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset to 0.
`timescale 1ns/1ps
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/ser2par_cdc.sv
// Serial-to-parallel converter: shifts on clka, hands words to clkb over a
// toggle req/ack handshake; only the toggles cross, the hold register is quiescent.
`timescale 1ns/1ps
module ser2par_cdc
  import ser2par_cdc_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clka,
  input  logic clkb,
  input  logic rst_n,
  ser2par_cdc_if.slave bus
);
  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  // clka domain
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_hold_a;
  logic          r_req_tog;
  logic          r_short;
  logic          r_ovf;
  logic          w_ack_sync;
  logic [DW-1:0] w_next;

  // clkb domain
  logic [DW-1:0] r_db;
  logic          r_valid;
  logic          r_ack_tog;
  logic          w_req_sync;
  logic          w_new_req;
  logic          w_capture;

  always_comb begin
    w_next = MSB_FIRST ? {r_shift[DW-2:0], bus.da} : {bus.da, r_shift[DW-1:1]};
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_hold_a  <= '0;
      r_req_tog <= 1'b0;
      r_short   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_short <= 1'b0;
      r_ovf   <= 1'b0;
      if (!bus.wra_n) begin
        r_shift <= w_next;
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          // Busy while the previous toggle has not come back acknowledged
          if (r_req_tog == w_ack_sync) begin
            r_hold_a  <= w_next;
            r_req_tog <= ~r_req_tog;
          end else begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_cnt != '0) begin
        r_short <= 1'b1;
        r_cnt   <= '0;
        r_shift <= '0;
      end
    end
  end

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clkb),
    .rst_n (rst_n),
    .i_d   (r_req_tog),
    .o_q   (w_req_sync)
  );

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clka),
    .rst_n (rst_n),
    .i_d   (r_ack_tog),
    .o_q   (w_ack_sync)
  );

  always_comb begin
    w_new_req = (w_req_sync != r_ack_tog);
    w_capture = w_new_req && (!r_valid || bus.db_ready);
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      r_db      <= '0;
      r_valid   <= 1'b0;
      r_ack_tog <= 1'b0;
    end else if (w_capture) begin
      r_db      <= r_hold_a;
      r_valid   <= 1'b1;
      r_ack_tog <= ~r_ack_tog;
    end else if (r_valid && bus.db_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.db          = r_db;
  assign bus.db_valid    = r_valid;
  assign bus.short_frame = r_short;
  assign bus.overflow    = r_ovf;
endmodule

// File: doc/ser2par_cdc.md
Name: ser2par_cdc

Overview:
- Parametrised serial-to-parallel converter with a clock-domain crossing.
- Shifts a serial bit stream in on clka while the active-low frame strobe wra_n is low, and packs it into DW-bit words.
- Hands each word to the clkb domain over a toggle req/ack handshake; clkb side is a valid/ready port.
- Supports back-to-back words inside one frame, both bit orders, short-frame detection and overflow reporting.

Parameters:
- DW, 8, parallel word width (>=2).
- MSB_FIRST, 1, 1 = first serial bit lands in db[DW-1]; 0 = first bit lands in db[0].
- SYNC_STAGES, 2, flops per synchroniser (>=2).

Ports:
- clka  in  1  serial-side clock.
- rst_n  in  1  reset, asynchronous, active-low; resets both domains. Deassertion is synchronised per domain by the integrator.
- clkb  in  1  parallel-side clock, asynchronous to clka.
- wra_n  in  1  frame strobe, active-low, clka domain.
- da  in  1  serial data, sampled on clka while wra_n=0.
- db  out  DW  parallel word, clkb domain.
- db_valid  out  1  db holds an unconsumed word.
- db_ready  in  1  consumer accepts db when db_valid & db_ready.
- short_frame  out  1  one-clka pulse: frame ended with 1..DW-1 bits pending.
- overflow  out  1  one-clka pulse: completed word dropped because the crossing was busy.

Behaviour:
- Reset values: db=0, db_valid=0, short_frame=0, overflow=0. Bit counter=0, shift reg=0, req/ack toggles=0.
- clka shifting:
  - Each clka edge with wra_n=0 shifts da in and increments the bit counter (width clog2(DW)).
  - MSB_FIRST=1: shift left, insert at bit 0.
  - MSB_FIRST=0: shift right, insert at bit DW-1.
- Word completion (edge where counter = DW-1 and wra_n=0):
  - The assembled word including the current da is formed, and the counter wraps to 0. The shift continues seamlessly, so a 2*DW-bit frame yields two words.
  - If not busy (req_tog == synchronised ack): load the word into hold_a, flip req_tog. hold_a then stays stable until ack returns.
  - If busy: drop the word and pulse overflow. hold_a and req_tog are unchanged.
- Frame end:
  - A clka edge with wra_n=1 and counter != 0 pulses short_frame and clears counter and shift reg. Partial bits are never transferred.
  - wra_n=1 with counter=0: idle, no pulse.
- clkb side:
  - req_tog is synchronised through SYNC_STAGES flops. A new request is detected when the synchronised req differs from local ack_tog.
  - Capture occurs on a new request only if db_valid=0, or db_valid & db_ready in the same cycle. On capture: db <= hold_a, db_valid <= 1, ack_tog flips.
  - Otherwise the request waits (no ack). This back-pressures clka; further completed words overflow.
  - db_valid & db_ready without a new capture clears db_valid. db holds its value.
- ack_tog is synchronised back to clka through SYNC_STAGES flops.
- Latency: from the clka edge completing a word to db_valid high is SYNC_STAGES+1 clkb edges, plus up to one clkb period of sampling uncertainty. The round trip until busy clears is roughly twice the crossing latency.
- Throughput: lossless only if DW clka periods exceed the round-trip handshake time; otherwise overflow pulses.
- Reset mid-frame or mid-handshake: all state clears immediately; a pending word is lost and no stale db_valid appears after reset.
- Only single-bit toggles cross domains; the data bus crosses only while quiescent.

Decomposition:
- Shared package: default constants DW_DEF=8 and SYNC_STAGES_DEF=2.
- Sub-module cdc_sync_bit (parameter STAGES, async active-low reset to 0). Instantiated twice: req into clkb, ack into clka.
- Counter width is derived locally from DW.

Test Plan:
- DW=8, MSB_FIRST=1, wra_n low for 8 clka with da=1,0,1,0,0,1,0,1 -> db=0xA5, db_valid within SYNC_STAGES+2 clkb; no pulses.
- MSB_FIRST=0, same bit sequence -> db=0xA5 bit-reversed = 0xA5 is symmetric, so use 1,1,0,0,0,0,0,0 -> db=0x03 (MSB_FIRST=1 gives 0xC0).
- clkb 4x faster than clka, 16-bit frame 0x3C then 0xC3, db_ready=1 -> two db_valid beats 0x3C then 0xC3, no overflow.
- clkb 8x slower than clka, 16-bit frame -> first word 0x3C delivered; overflow pulses once at bit 16; no second beat.
- 5-bit frame then 8-bit frame 0x81 -> short_frame pulses once after bit 5; single beat db=0x81.
- db_ready=0 holding word 0x11, then send 0x22 -> db stays 0x11. Raising db_ready shows 0x22 next. A third word sent while 0x22 is pending pulses overflow.
- Assert rst_n mid-frame (bit 4) and mid-handshake -> all outputs 0 immediately; the next full frame 0x5A delivers cleanly.
